// File: rtl/bcd_seq_addsub.sv
// Sequential packed-BCD adder/subtractor: one digit per clock, LSD first.
// Subtraction uses nine's complement of B with an initial carry of 1.
module bcd_seq_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  op_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_r, b_r, sum_r;
  logic            sub_r, carry, cout_r, err_r;
  logic [IW-1:0]   idx;

  logic [3:0]      a_dig, b_dig, bd, dig;
  logic [4:0]      s, s_adj;
  logic            carry_nxt, bad, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign err       = err_r;

  // Digit select, invalid-digit detect and single-digit BCD add
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    bad   = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        a_dig = a_r[4*i +: 4];
        b_dig = b_r[4*i +: 4];
      end
      if (a_r[4*i +: 4] > 4'd9 || b_r[4*i +: 4] > 4'd9)
        bad = 1'b1;
    end
    bd    = sub_r ? (4'd9 - b_dig) : b_dig;
    s     = {1'b0, a_dig} + {1'b0, bd} + {4'b0000, carry};
    s_adj = s + 5'd6;
    if (s > 5'd9) begin
      dig       = s_adj[3:0];
      carry_nxt = 1'b1;
    end else begin
      dig       = s[3:0];
      carry_nxt = 1'b0;
    end
    last = (idx == IW'(DIGITS - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operand latch, per-digit result write and final flags
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      sub_r  <= 1'b0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      err_r  <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            sub_r  <= op_sub;
            idx    <= '0;
            carry  <= op_sub;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i))
              sum_r[4*i +: 4] <= dig;
          end
          idx   <= idx + IW'(1);
          carry <= carry_nxt;
          // Final digit: an invalid operand overrides the digit just written
          if (last) begin
            if (bad) begin
              sum_r  <= '0;
              cout_r <= 1'b0;
              err_r  <= 1'b1;
            end else begin
              cout_r <= carry_nxt;
              err_r  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_addsub.sv
// Directed bench for bcd_seq_addsub (DIGITS=4), hand-computed expectations.
module tb_bcd_seq_addsub;

  localparam int unsigned DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        err;

  int total = 0;
  int bad   = 0;

  bcd_seq_addsub #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, measure latency, check result, then hand off
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic sub, input logic [15:0] e_sum, input logic e_cout,
                        input logic e_err);
    int lat;
    a        = ta;
    b        = tb_v;
    op_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, ".lat"},  lat, DIGITS);
    check({tag, ".sum"},  sum, e_sum);
    check({tag, ".cout"}, cout, e_cout);
    check({tag, ".err"},  err, e_err);
    check({tag, ".rdy"},  in_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, ".ovl0"}, out_valid, 1'b0);
    check({tag, ".rdy1"}, in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst.rdy",  in_ready, 1'b1);
    check("rst.ovl",  out_valid, 1'b0);
    check("rst.sum",  sum, 16'h0000);
    check("rst.cout", cout, 1'b0);
    check("rst.err",  err, 1'b0);

    // Idle hold: no in_valid, stays ready
    repeat (3) @(posedge clk);
    #1 check("idle.rdy", in_ready, 1'b1);

    run_op("add",    16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("wrap",   16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub",    16'h0500, 16'h0123, 1'b1, 16'h0377, 1'b1, 1'b0);
    run_op("subneg", 16'h0123, 16'h0500, 1'b1, 16'h9623, 1'b0, 1'b0);
    run_op("inva",   16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
    run_op("sub0",   16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("add5k",  16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("invb",   16'h0001, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1);
    run_op("subeq",  16'h4321, 16'h4321, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure: result held, in_valid pulses ignored
    a = 16'h0458; b = 16'h0367; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (DIGITS) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      a = 16'h1111; b = 16'h2222; op_sub = 1'b1; in_valid = (k % 2 == 0);
      @(posedge clk);
      #1;
      check("bp.ovl",  out_valid, 1'b1);
      check("bp.sum",  sum, 16'h0825);
      check("bp.cout", cout, 1'b0);
      check("bp.rdy",  in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp.ovl0", out_valid, 1'b0);
    check("bp.rdy1", in_ready, 1'b1);
    @(posedge clk);
    #1 check("bp.idle", in_ready, 1'b1);

    // Reset mid-RUN, on the edge that would process digit 2
    a = 16'h9999; b = 16'h9999; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mrst.rdy", in_ready, 1'b1);
    check("mrst.ovl", out_valid, 1'b0);
    check("mrst.sum", sum, 16'h0000);
    repeat (DIGITS + 1) @(posedge clk);
    #1 check("mrst.noovl", out_valid, 1'b0);
    run_op("post", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
